uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers. Each requester offers bytes through a valid/ack handshake. The arbiter grants one requester at a time, holds the grant for a burst of up to MAX_BURST bytes, and sequences the transmitter's start/active/done handshake. It sits between the producer blocks and the TX side of uart_controller, and a start timeout guards against a transmitter that never responds.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Grants are held for bursts of up to MAX_BURST bytes and guarded by a start timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ack,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Tx_Ready,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy,
  output logic                   o_Timeout_Err,
  input  logic                   i_Err_Clear
);

  localparam int             PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int             BW        = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0]  PTR_RST   = PW'(NUM_REQ - 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
  localparam logic [7:0]     TO_LIMIT  = 8'(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_LOAD        = 2'd1,
    S_WAIT_ACTIVE = 2'd2,
    S_WAIT_DONE   = 2'd3
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_gidx;
  logic [BW-1:0]  r_burst;
  logic [7:0]     r_tcnt;
  logic           r_last;

  logic [NUM_REQ-1:0] w_pick;
  logic [PW-1:0]      w_pick_idx;
  logic [7:0]         w_bytes [NUM_REQ];
  logic [7:0]         w_sel_byte;
  logic               w_sel_last;
  logic               w_sel_valid;
  logic               w_release;

  // First valid requester found searching upward from ptr+1, wrapping.
  function automatic logic [NUM_REQ-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [PW-1:0] ptr);
    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] f_onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_bytes[k] = i_Req_Byte[8*k +: 8];
  end

  assign w_pick      = f_rr_pick(i_Req_Valid, r_ptr);
  assign w_pick_idx  = f_onehot_idx(w_pick);
  assign w_sel_byte  = w_bytes[r_gidx];
  assign w_sel_last  = i_Req_Last[r_gidx];
  assign w_sel_valid = i_Req_Valid[r_gidx];
  assign w_release   = r_last | (r_burst == BURST_MAX) | ~w_sel_valid;

  // Done takes priority over active in WAIT_ACTIVE so a frame ending in the
  // same cycle it is reported active can never strand the FSM in WAIT_DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_RST;
      r_gidx        <= '0;
      r_burst       <= '0;
      r_tcnt        <= 8'd0;
      r_last        <= 1'b0;
      o_Grant       <= '0;
      o_Req_Ack     <= '0;
      o_Tx_Ready    <= 1'b0;
      o_Tx_Byte     <= 8'h00;
      o_Busy        <= 1'b0;
      o_Timeout_Err <= 1'b0;
    end else begin
      o_Req_Ack  <= '0;
      o_Tx_Ready <= 1'b0;
      if (i_Err_Clear) begin
        o_Timeout_Err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (|i_Req_Valid) begin
            o_Grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_burst <= '0;
            o_Busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_Tx_Byte  <= w_sel_byte;
          r_last     <= w_sel_last;
          o_Req_Ack  <= o_Grant;
          o_Tx_Ready <= 1'b1;
          if (r_burst != BURST_MAX) begin
            r_burst <= r_burst + BW'(1);
          end
          r_tcnt  <= 8'd0;
          r_state <= S_WAIT_ACTIVE;
        end
        S_WAIT_ACTIVE, S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            if (w_release) begin
              r_ptr   <= r_gidx;
              o_Grant <= '0;
              o_Busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_LOAD;
            end
          end else if (r_state == S_WAIT_ACTIVE) begin
            if (i_Tx_Active) begin
              r_state <= S_WAIT_DONE;
            end else if (r_tcnt == TO_LIMIT) begin
              o_Timeout_Err <= 1'b1;
              r_ptr         <= r_gidx;
              o_Grant       <= '0;
              o_Busy        <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
        end
        default: begin
          o_Grant <= '0;
          o_Busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int MAX_BURST     = 4;
  localparam int START_TIMEOUT = 16;
  localparam int DEPTH         = 1024;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   i_Req_Valid = '0;
  logic [8*NUM_REQ-1:0] i_Req_Byte  = '0;
  logic [NUM_REQ-1:0]   i_Req_Last  = '0;
  logic [NUM_REQ-1:0]   o_Req_Ack;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Tx_Ready;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active = 1'b0;
  logic                 i_Tx_Done   = 1'b0;
  logic                 o_Busy;
  logic                 o_Timeout_Err;
  logic                 i_Err_Clear;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_Req_Valid(i_Req_Valid), .i_Req_Byte(i_Req_Byte), .i_Req_Last(i_Req_Last),
    .o_Req_Ack(o_Req_Ack), .o_Grant(o_Grant),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Busy(o_Busy), .o_Timeout_Err(o_Timeout_Err), .i_Err_Clear(i_Err_Clear)
  );

  always #5 clk = ~clk;

  // Per-requester byte queues: tail written by the stimulus, head by the driver.
  logic [7:0] m_byte [NUM_REQ][DEPTH];
  logic       m_last [NUM_REQ][DEPTH];
  int         head [NUM_REQ] = '{default: 0};
  int         tail [NUM_REQ];

  bit q_flush, tx_abort, tx_mute, force_done;
  bit tx_on = 1'b0;
  int tx_cnt = 0;
  int tx_act, tx_done;

  logic [15:0] log_q [$];
  logic [15:0] exp_q [$];
  int          log_rd;
  int          n_cmp, n_err;
  int          m_ptr;

  // Requesters: pop on ack, present the next queued byte half a cycle later.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (q_flush) head[k] = tail[k];
      else if (o_Req_Ack[k] && head[k] < tail[k]) head[k] = head[k] + 1;
      if (head[k] < tail[k]) begin
        i_Req_Valid[k]       = 1'b1;
        i_Req_Byte[8*k +: 8] = m_byte[k][head[k] % DEPTH];
        i_Req_Last[k]        = m_last[k][head[k] % DEPTH];
      end else begin
        i_Req_Valid[k]       = 1'b0;
        i_Req_Byte[8*k +: 8] = 8'h00;
        i_Req_Last[k]        = 1'b0;
      end
    end
  end

  // Transmitter: active from tx_act, one-cycle done at tx_done negedges after the strobe.
  always @(negedge clk) begin
    if (tx_abort) tx_on = 1'b0;
    else if (!tx_mute && o_Tx_Ready) begin
      tx_on  = 1'b1;
      tx_cnt = 0;
    end else if (tx_on) tx_cnt = tx_cnt + 1;
    i_Tx_Active = tx_on && tx_cnt >= tx_act && tx_cnt < tx_done;
    i_Tx_Done   = (tx_on && tx_cnt == tx_done) || force_done;
    if (tx_on && tx_cnt == tx_done) tx_on = 1'b0;
  end

  always @(negedge clk) begin
    if (o_Tx_Ready) log_q.push_back({o_Req_Ack, o_Grant, o_Tx_Byte});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int k, input logic [7:0] b, input logic l);
    m_byte[k][tail[k] % DEPTH] = b;
    m_last[k][tail[k] % DEPTH] = l;
    tail[k] = tail[k] + 1;
  endtask

  task automatic exp_push(input int k, input logic [7:0] b);
    logic [NUM_REQ-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    exp_q.push_back({oh, oh, b});
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < NUM_REQ; k++) if (head[k] != tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: serve requesters round-robin from the last owner, each grant
  // ending at a last byte, after MAX_BURST bytes, or when the queue runs dry.
  task automatic model_run();
    int h [NUM_REQ];
    int p, g, n;
    logic l;
    foreach (h[k]) h[k] = head[k];
    p = m_ptr;
    forever begin
      g = -1;
      for (int i = 1; i <= NUM_REQ; i++) begin
        if (g < 0 && h[(p + i) % NUM_REQ] < tail[(p + i) % NUM_REQ]) g = (p + i) % NUM_REQ;
      end
      if (g < 0) break;
      n = 0;
      do begin
        exp_push(g, m_byte[g][h[g] % DEPTH]);
        l    = m_last[g][h[g] % DEPTH];
        h[g] = h[g] + 1;
        n++;
      end while (!l && n < MAX_BURST && h[g] < tail[g]);
      p = g;
    end
    m_ptr = p;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(log_q.size() - log_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log_rd + i < log_q.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(log_q[log_rd + i]), 32'(exp_q[i]));
    end
    log_rd = log_q.size();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; q_flush = 1'b1; tx_abort = 1'b1; force_done = 1'b0;
    tick();
    chk("reset_outputs", 32'({o_Grant, o_Req_Ack, o_Tx_Ready, o_Tx_Byte, o_Busy, o_Timeout_Err}), 32'd0);
    reset = 1'b0; q_flush = 1'b0; tx_abort = 1'b0;
    m_ptr  = NUM_REQ - 1;
    log_rd = log_q.size();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (!o_Busy && !tx_on && queues_empty()) ok = 1'b1;
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (o_Tx_Ready) ok = 1'b1;
    end
    chk({tag, "_strobe"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [NUM_REQ-1:0] exp, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (o_Grant != '0) ok = 1'b1;
    end
    chk({tag, "_grant"}, 32'(o_Grant), 32'(exp));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; log_rd = 0; m_ptr = NUM_REQ - 1;
    reset = 1'b1; i_Err_Clear = 1'b0;
    q_flush = 1'b0; tx_abort = 1'b0; tx_mute = 1'b0; force_done = 1'b0;
    tx_act = 2; tx_done = 10;
    foreach (tail[k]) tail[k] = 0;
    tick();

    // Single byte with exact handshake timing
    do_reset();
    enq(1, 8'hA5, 1'b1);
    tick();
    chk("t1_grant_e0", 32'(o_Grant), 32'h2);
    chk("t1_busy_e0", 32'(o_Busy), 32'd1);
    chk("t1_ready_e0", 32'(o_Tx_Ready), 32'd0);
    tick();
    chk("t1_ready_e1", 32'(o_Tx_Ready), 32'd1);
    chk("t1_ack_e1", 32'(o_Req_Ack), 32'h2);
    chk("t1_byte_e1", 32'(o_Tx_Byte), 32'hA5);
    tick();
    chk("t1_ready_e2", 32'(o_Tx_Ready), 32'd0);
    chk("t1_ack_e2", 32'(o_Req_Ack), 32'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (i_Tx_Done) seen = 1'b1;
      end
      chk("t1_done_seen", 32'(seen), 32'd1);
    end
    chk("t1_grant_release", 32'(o_Grant), 32'd0);
    chk("t1_busy_release", 32'(o_Busy), 32'd0);
    exp_push(1, 8'hA5);
    check_log("t1");

    // Round robin among three, then two raised together
    do_reset();
    tx_act = 1; tx_done = 6;
    enq(0, 8'h01, 1'b1); enq(2, 8'h22, 1'b1); enq(3, 8'h33, 1'b1);
    exp_push(0, 8'h01); exp_push(2, 8'h22); exp_push(3, 8'h33);
    wait_idle("t2a", 200);
    check_log("t2a");
    enq(0, 8'h0A, 1'b1); enq(3, 8'h3B, 1'b1);
    exp_push(0, 8'h0A); exp_push(3, 8'h3B);
    wait_idle("t2b", 200);
    check_log("t2b");

    // Burst cap lets a waiting requester in
    do_reset();
    for (int i = 0; i < 6; i++) enq(2, 8'(16 + i), 1'b0);
    wait_grant("t3", 4'b0100, 10);
    enq(1, 8'hB1, 1'b1);
    for (int i = 0; i < 4; i++) exp_push(2, 8'(16 + i));
    exp_push(1, 8'hB1);
    exp_push(2, 8'h14); exp_push(2, 8'h15);
    wait_idle("t3", 400);
    check_log("t3");

    // Last flag releases before the cap even with more bytes pending
    do_reset();
    enq(0, 8'h75, 1'b0); enq(0, 8'h76, 1'b0); enq(0, 8'h77, 1'b1); enq(0, 8'h78, 1'b1);
    enq(1, 8'h91, 1'b1);
    exp_push(0, 8'h75); exp_push(0, 8'h76); exp_push(0, 8'h77);
    exp_push(1, 8'h91); exp_push(0, 8'h78);
    wait_idle("t4", 400);
    check_log("t4");

    // Start timeout, error clear, then normal service
    tx_mute = 1'b1;
    enq(0, 8'h5A, 1'b1);
    wait_ready("t5", 20);
    repeat (START_TIMEOUT) tick();
    chk("t5_err_before", 32'(o_Timeout_Err), 32'd0);
    chk("t5_grant_before", 32'(o_Grant), 32'h1);
    tick();
    chk("t5_err_set", 32'(o_Timeout_Err), 32'd1);
    chk("t5_grant_cleared", 32'(o_Grant), 32'd0);
    chk("t5_busy_cleared", 32'(o_Busy), 32'd0);
    i_Err_Clear = 1'b1;
    tick();
    i_Err_Clear = 1'b0;
    chk("t5_err_clear", 32'(o_Timeout_Err), 32'd0);
    tx_mute = 1'b0;
    enq(0, 8'h5B, 1'b1);
    exp_push(0, 8'h5A); exp_push(0, 8'h5B);
    wait_idle("t5", 200);
    check_log("t5");

    // Reset in WAIT_DONE of the second burst byte
    do_reset();
    tx_act = 1; tx_done = 8;
    enq(3, 8'hC0, 1'b0); enq(3, 8'hC1, 1'b0); enq(3, 8'hC2, 1'b0);
    wait_ready("t6_first", 20);
    wait_ready("t6_second", 40);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (i_Tx_Active) seen = 1'b1;
      end
      chk("t6_active_seen", 32'(seen), 32'd1);
    end
    exp_push(3, 8'hC0); exp_push(3, 8'hC1);
    check_log("t6_pre");
    do_reset();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    chk("t6_stray_done", 32'({o_Grant, o_Req_Ack, o_Tx_Ready, o_Busy}), 32'd0);
    for (int k = 0; k < NUM_REQ; k++) enq(k, 8'(224 + k), 1'b1);
    model_run();
    wait_grant("t6_after", 4'b0001, 10);
    wait_idle("t6", 400);
    check_log("t6");

    // Randomized traffic against the reference model
    for (int r = 0; r < 10; r++) begin
      int nm, len;
      tx_act  = int'($urandom_range(0, 2));
      tx_done = tx_act + 1 + int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) tx_act = tx_done + 1;
      for (int k = 0; k < NUM_REQ; k++) begin
        nm = int'($urandom_range(0, 2));
        for (int m = 0; m < nm; m++) begin
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) enq(k, 8'($urandom), (b == len - 1));
        end
      end
      model_run();
      wait_idle($sformatf("rnd%0d", r), 2000);
      check_log($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
